// File: rtl/ps2_key_decoder_pkg.sv
// Shared PS/2 constants, frame payload layout and receive FSM encoding.
package ps2_key_decoder_pkg;

    localparam int unsigned ASCII_W        = 7;
    localparam int unsigned SCAN_W         = 8;
    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned BITCNT_W       = 4;

    localparam logic [SCAN_W-1:0] PS2_BREAK = 8'hF0;
    localparam logic [SCAN_W-1:0] PS2_EXT   = 8'hE0;

    // Frame bits after the start bit, in arrival order LSB first.
    typedef struct packed {
        logic              stop;
        logic              parity;
        logic [SCAN_W-1:0] data;
    } ps2_payload_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    // Odd parity over data+parity and a high stop bit.
    function automatic logic frame_ok(input ps2_payload_t p);
        return (^{p.parity, p.data}) & p.stop;
    endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 scancode to ASCII map for A-Z, 0-9 and space.
//   scan     : 8-bit make code
//   ascii_c  : 7-bit ASCII (0 when unmapped)
//   mapped_c : 1 when scan is in the supported subset
module ps2_scan_to_ascii
    import ps2_key_decoder_pkg::*;
(
    input  logic [SCAN_W-1:0]  scan,
    output logic [ASCII_W-1:0] ascii_c,
    output logic               mapped_c
);

    always_comb begin
        ascii_c  = '0;
        mapped_c = 1'b1;
        case (scan)
            8'h1C: ascii_c = 7'h41;
            8'h32: ascii_c = 7'h42;
            8'h21: ascii_c = 7'h43;
            8'h23: ascii_c = 7'h44;
            8'h24: ascii_c = 7'h45;
            8'h2B: ascii_c = 7'h46;
            8'h34: ascii_c = 7'h47;
            8'h33: ascii_c = 7'h48;
            8'h43: ascii_c = 7'h49;
            8'h3B: ascii_c = 7'h4A;
            8'h42: ascii_c = 7'h4B;
            8'h4B: ascii_c = 7'h4C;
            8'h3A: ascii_c = 7'h4D;
            8'h31: ascii_c = 7'h4E;
            8'h44: ascii_c = 7'h4F;
            8'h4D: ascii_c = 7'h50;
            8'h15: ascii_c = 7'h51;
            8'h2D: ascii_c = 7'h52;
            8'h1B: ascii_c = 7'h53;
            8'h2C: ascii_c = 7'h54;
            8'h3C: ascii_c = 7'h55;
            8'h2A: ascii_c = 7'h56;
            8'h1D: ascii_c = 7'h57;
            8'h22: ascii_c = 7'h58;
            8'h35: ascii_c = 7'h59;
            8'h1A: ascii_c = 7'h5A;
            8'h45: ascii_c = 7'h30;
            8'h16: ascii_c = 7'h31;
            8'h1E: ascii_c = 7'h32;
            8'h26: ascii_c = 7'h33;
            8'h25: ascii_c = 7'h34;
            8'h2E: ascii_c = 7'h35;
            8'h36: ascii_c = 7'h36;
            8'h3D: ascii_c = 7'h37;
            8'h3E: ascii_c = 7'h38;
            8'h46: ascii_c = 7'h39;
            8'h29: ascii_c = 7'h20;
            default: mapped_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the raw lines, deserialises 11-bit
// frames, tracks E0/F0 prefixes and holds the ASCII of the held key.
//   clk, resetn      : 50 MHz clock, async active-low reset
//   ps2_clk, ps2_dat : raw asynchronous PS/2 lines
//   ascii            : ASCII of currently held mapped key, 0 when none
//   key_valid        : 1-cycle pulse when ascii takes a new nonzero value
//   key_released     : 1-cycle pulse when ascii returns to 0
//   frame_err        : 1-cycle pulse on parity/start/stop/timeout error
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ps2_clk,
    input  logic               ps2_dat,
    output logic [ASCII_W-1:0] ascii,
    output logic               key_valid,
    output logic               key_released,
    output logic               frame_err
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BITCNT_W-1:0] STOP_IDX = BITCNT_W'(PS2_FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    rx_state_e              state_q, state_d;
    logic [BITCNT_W-1:0]    bitcnt_q, bitcnt_d;
    ps2_payload_t           payload_q, payload_d;
    logic [TO_W-1:0]        to_q, to_d;

    logic [ASCII_W-1:0]     ascii_q, ascii_d;
    logic                   valid_q, valid_d;
    logic                   rel_q, rel_d;
    logic                   ferr_q, ferr_d;
    logic                   ext_q, ext_d;
    logic                   brk_q, brk_d;

    logic                   sync_clk_c, dat_s_c, fall_c;
    logic                   byte_rdy_c, err_c;
    logic [ASCII_W-1:0]     map_ascii_c;
    logic                   map_hit_c;

    // Metastability synchronisers; preset high so reset release sees an idle bus.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
        sync_clk_c = clk_sync_q[SYNC_STAGES-1];
        dat_s_c    = dat_sync_q[SYNC_STAGES-1];
        clk_prev_d = sync_clk_c;
        fall_c     = clk_prev_q & ~sync_clk_c;
    end

    // Receive FSM: start-bit detect, 10-bit shift, per-edge timeout, frame check.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        payload_d  = payload_q;
        to_d       = to_q;
        byte_rdy_c = 1'b0;
        err_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                to_d = '0;
                if (fall_c && !dat_s_c) begin
                    state_d  = ST_RECV;
                    bitcnt_d = BITCNT_W'(1);
                end
            end
            ST_RECV: begin
                if (fall_c) begin
                    to_d      = '0;
                    payload_d = ps2_payload_t'({dat_s_c, payload_q[$bits(ps2_payload_t)-1:1]});
                    if (bitcnt_q == STOP_IDX) begin
                        state_d  = ST_CHECK;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    end
                end else if (to_q == TO_LAST) begin
                    err_c    = 1'b1;
                    state_d  = ST_IDLE;
                    bitcnt_d = '0;
                    to_d     = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_ok(payload_q)) begin
                    byte_rdy_c = 1'b1;
                end else begin
                    err_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ps2_scan_to_ascii u_map (
        .scan     (payload_q.data),
        .ascii_c  (map_ascii_c),
        .mapped_c (map_hit_c)
    );

    // Prefix tracking and held-key update; any frame error drops pending prefixes.
    always_comb begin
        ascii_d = ascii_q;
        valid_d = 1'b0;
        rel_d   = 1'b0;
        ferr_d  = err_c;
        ext_d   = ext_q;
        brk_d   = brk_q;
        if (err_c) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_rdy_c) begin
            if (payload_q.data == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (payload_q.data == PS2_BREAK) begin
                brk_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                brk_d = 1'b0;
                // Only the key currently shown can be released; stale breaks are dropped.
                if (map_hit_c && (map_ascii_c == ascii_q) && (ascii_q != '0)) begin
                    ascii_d = '0;
                    rel_d   = 1'b1;
                end
            end else if (map_hit_c && (map_ascii_c != ascii_q)) begin
                ascii_d = map_ascii_c;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            payload_q  <= '0;
            to_q       <= '0;
            ascii_q    <= '0;
            valid_q    <= 1'b0;
            rel_q      <= 1'b0;
            ferr_q     <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            payload_q  <= payload_d;
            to_q       <= to_d;
            ascii_q    <= ascii_d;
            valid_q    <= valid_d;
            rel_q      <= rel_d;
            ferr_q     <= ferr_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
        end
    end

    assign ascii        = ascii_q;
    assign key_valid    = valid_q;
    assign key_released = rel_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: drives PS/2 frames and checks the held
// ASCII value and the event pulse counts against hand-computed values.
module tb_ps2_key_decoder;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [6:0] ascii;
    logic       key_valid;
    logic       key_released;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int valid_cyc = 0;
    int n_valid = 0;
    int n_rel = 0;
    int n_err = 0;
    int n_wide = 0;
    int n_multi = 0;
    logic prev_v = 1'b0, prev_r = 1'b0, prev_e = 1'b0;

    always #10 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES (50000),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .ascii        (ascii),
        .key_valid    (key_valid),
        .key_released (key_released),
        .frame_err    (frame_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters, width and exclusivity tracking.
    always @(negedge clk) begin
        if (resetn) begin
            if (key_valid) begin
                n_valid++;
                valid_cyc = cyc;
            end
            if (key_released) n_rel++;
            if (frame_err) n_err++;
            if ((key_valid && prev_v) || (key_released && prev_r) || (frame_err && prev_e)) n_wide++;
            if ((int'(key_valid) + int'(key_released) + int'(frame_err)) > 1) n_multi++;
        end
        prev_v = key_valid;
        prev_r = key_released;
        prev_e = frame_err;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends frame bits f[0..nbits-1]; clock low phases start just after a negedge.
    task automatic send_raw(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_dat = f[i];
            wait_cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        wait_cyc(HALF);
        ps2_dat = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0);
        send_raw(mk_frame(b, bad_par), 11);
        wait_cyc(10);
    endtask

    initial begin
        wait_cyc(5);
        chk_eq("rst_ascii", 32'(ascii), 32'h00);
        chk_eq("rst_valid", 32'(key_valid), 32'h0);
        chk_eq("rst_rel",   32'(key_released), 32'h0);
        chk_eq("rst_err",   32'(frame_err), 32'h0);
        resetn = 1'b1;
        wait_cyc(5);

        // Single press of A.
        send_byte(8'h1C);
        chk_eq("a_ascii", 32'(ascii), 32'h41);
        chk_eq("a_nvalid", 32'(n_valid), 32'd1);
        chk_eq("a_latency", 32'(valid_cyc - stop_cyc), 32'd4);
        chk_eq("a_nerr", 32'(n_err), 32'd0);

        // Typematic repeat then break.
        send_byte(8'h1C);
        chk_eq("rep_ascii", 32'(ascii), 32'h41);
        chk_eq("rep_nvalid", 32'(n_valid), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk_eq("brk_ascii", 32'(ascii), 32'h00);
        chk_eq("brk_nrel", 32'(n_rel), 32'd1);

        // Rollover: 1 then 2; break of 1 is stale.
        send_byte(8'h16);
        chk_eq("one_ascii", 32'(ascii), 32'h31);
        send_byte(8'h1E);
        chk_eq("two_ascii", 32'(ascii), 32'h32);
        send_byte(8'hF0);
        send_byte(8'h16);
        chk_eq("stale_ascii", 32'(ascii), 32'h32);
        chk_eq("roll_nvalid", 32'(n_valid), 32'd3);
        chk_eq("roll_nrel", 32'(n_rel), 32'd1);

        // Parity error and timeout.
        send_byte(8'h1C, 1'b1);
        chk_eq("par_nerr", 32'(n_err), 32'd1);
        chk_eq("par_ascii", 32'(ascii), 32'h32);
        send_raw(mk_frame(8'h1C, 1'b0), 5);
        wait_cyc(50100);
        chk_eq("to_nerr", 32'(n_err), 32'd2);
        chk_eq("to_ascii", 32'(ascii), 32'h32);
        send_byte(8'h29);
        chk_eq("spc_ascii", 32'(ascii), 32'h20);
        chk_eq("spc_nvalid", 32'(n_valid), 32'd4);

        // A frame error drops a pending break, so 1C is a make.
        send_byte(8'hF0);
        send_byte(8'h22, 1'b1);
        send_byte(8'h1C);
        chk_eq("errbrk_nerr", 32'(n_err), 32'd3);
        chk_eq("errbrk_ascii", 32'(ascii), 32'h41);
        chk_eq("errbrk_nvalid", 32'(n_valid), 32'd5);

        // Extended and unmapped codes are silent.
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk_eq("clr_ascii", 32'(ascii), 32'h00);
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'h05);
        chk_eq("ext_ascii", 32'(ascii), 32'h00);
        chk_eq("ext_nvalid", 32'(n_valid), 32'd5);
        chk_eq("ext_nrel", 32'(n_rel), 32'd2);
        chk_eq("ext_nerr", 32'(n_err), 32'd3);

        // Async reset mid-frame.
        send_byte(8'h1C);
        chk_eq("pre_rst_ascii", 32'(ascii), 32'h41);
        send_raw(mk_frame(8'h45, 1'b0), 4);
        resetn = 1'b0;
        #1;
        chk_eq("async_rst_ascii", 32'(ascii), 32'h00);
        wait_cyc(5);
        resetn = 1'b1;
        wait_cyc(5);
        send_byte(8'h45);
        chk_eq("post_rst_ascii", 32'(ascii), 32'h30);
        chk_eq("post_rst_nvalid", 32'(n_valid), 32'd7);

        chk_eq("pulse_width", 32'(n_wide), 32'd0);
        chk_eq("pulse_excl", 32'(n_multi), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
